// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: shared types and constants for the sequential multiply/divide unit.
//   state_e           - FSM state encoding (IDLE, RUN, DONE)
//   OP_MUL / OP_DIV   - operation select values on the op input
//   DIV_ZERO_QUOTIENT - all-ones quotient for divide by zero; slice to WIDTH bits
package muldiv_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    // Wide enough for any practical WIDTH; users take the low WIDTH bits.
    localparam logic [63:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/result bundle between the register bank side and muldiv_seq.
//   start, op, operand_a, operand_b, dest_reg - request (master drives)
//   busy, done, reg_write, write_reg           - status and write-back control (slave drives)
//   result_lo, result_hi, div_by_zero          - results (slave drives)
interface muldiv_seq_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 3
);
    logic              start;
    logic              op;
    logic [WIDTH-1:0]  operand_a;
    logic [WIDTH-1:0]  operand_b;
    logic [ADDR_W-1:0] dest_reg;
    logic              busy;
    logic              done;
    logic              reg_write;
    logic [ADDR_W-1:0] write_reg;
    logic [WIDTH-1:0]  result_lo;
    logic [WIDTH-1:0]  result_hi;
    logic              div_by_zero;

    modport master (
        output start, op, operand_a, operand_b, dest_reg,
        input  busy, done, reg_write, write_reg, result_lo, result_hi, div_by_zero
    );

    modport slave (
        input  start, op, operand_a, operand_b, dest_reg,
        output busy, done, reg_write, write_reg, result_lo, result_hi, div_by_zero
    );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide datapath.
//   op               - OP_MUL: shift-add step, OP_DIV: restoring-divide step
//   acc_hi, acc_lo   - current accumulator ({product_hi, multiplier} or {rem, quotient})
//   opnd             - held operand (multiplicand or divisor)
//   next_hi, next_lo - accumulator after this iteration
module muldiv_step
    import muldiv_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             op,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;

    always_comb begin
        // Multiply: carry out of the add becomes the top bit after the right shift.
        sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH + 1){1'b0}});
        // Divide: remainder shifted left picks up the next dividend bit; may be WIDTH+1 bits.
        rem_sh = {acc_hi, acc_lo[WIDTH-1]};
        // Only used when rem_sh >= opnd, where the true difference fits in WIDTH bits.
        diff   = rem_sh[WIDTH-1:0] - opnd;

        if (op == OP_MUL) begin
            next_hi = sum[WIDTH:1];
            next_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end else if (rem_sh >= {1'b0, opnd}) begin
            next_hi = diff;
            next_lo = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            next_hi = rem_sh[WIDTH-1:0];
            next_lo = {acc_lo[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential 16-bit unsigned multiply/divide, one iteration per clock.
//   clock, reset_n - rising-edge clock, asynchronous active-low reset
//   bus (slave)    - request in (start/op/operands/dest_reg), status and results out
// A request in IDLE runs WIDTH iterations in RUN, then pulses done/reg_write for one
// cycle in DONE. Divide by zero skips RUN. All outputs are registered.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 3
) (
    input logic          clock,
    input logic          reset_n,
    muldiv_seq_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_e            state_q;
    logic              op_q;
    logic [WIDTH-1:0]  opnd_q;
    logic [WIDTH-1:0]  acc_hi_q;
    logic [WIDTH-1:0]  acc_lo_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [WIDTH-1:0]  res_lo_q;
    logic [WIDTH-1:0]  res_hi_q;
    logic [ADDR_W-1:0] wreg_q;
    logic              busy_q;
    logic              done_q;
    logic              dbz_q;
    logic [WIDTH-1:0]  step_hi;
    logic [WIDTH-1:0]  step_lo;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op      (op_q),
        .acc_hi  (acc_hi_q),
        .acc_lo  (acc_lo_q),
        .opnd    (opnd_q),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            wreg_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        op_q     <= bus.op;
                        wreg_q   <= bus.dest_reg;
                        acc_hi_q <= '0;
                        cnt_q    <= CNT_W'(WIDTH - 1);
                        busy_q   <= 1'b1;
                        // The shifting operand lives in acc_lo; the other one is held.
                        if (bus.op == OP_DIV) begin
                            opnd_q   <= bus.operand_b;
                            acc_lo_q <= bus.operand_a;
                        end else begin
                            opnd_q   <= bus.operand_a;
                            acc_lo_q <= bus.operand_b;
                        end
                        if (bus.op == OP_DIV && bus.operand_b == '0) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            dbz_q    <= 1'b1;
                            res_lo_q <= DIV_ZERO_QUOTIENT[WIDTH-1:0];
                            res_hi_q <= bus.operand_a;
                        end else begin
                            state_q <= RUN;
                            dbz_q   <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    acc_hi_q <= step_hi;
                    acc_lo_q <= step_lo;
                    cnt_q    <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q  <= DONE;
                        done_q   <= 1'b1;
                        res_lo_q <= step_lo;
                        res_hi_q <= step_hi;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.reg_write   = done_q;
    assign bus.write_reg   = wreg_q;
    assign bus.result_lo   = res_lo_q;
    assign bus.result_hi   = res_hi_q;
    assign bus.div_by_zero = dbz_q;
endmodule
